// File: rtl/instr_register_pkg.sv
// instr_register_pkg
// Shared definitions for the instruction register / ALU slice.
// Holds the opcode encoding and its width. Nothing here depends on the operand
// width, because that width is a module parameter.
package instr_register_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

endpackage : instr_register_pkg

// File: rtl/instr_alu.sv
// instr_alu
// Purely combinational signed ALU. The operands are sign-extended to
// 2*WIDTH, so every operation, including the full product, fits the result
// without truncation.
// Ports:
//   opcode  in  opcode_t       operation select
//   a       in  WIDTH          signed operand A
//   b       in  WIDTH          signed operand B
//   result  out 2*WIDTH        signed result
//   err     out 1              divide/modulo by zero
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  opcode_t              opcode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic                      b_is_zero;

    assign a_ext     = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext     = {{WIDTH{b[WIDTH-1]}}, b};
    assign b_is_zero = (b == '0);

    // Signed '/' and '%' truncate toward zero, and the remainder takes the
    // sign of the dividend. A zero divisor gives result 0 and raises err.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV: begin
                if (b_is_zero) err = 1'b1;
                else           result = a_ext / b_ext;
            end
            MOD: begin
                if (b_is_zero) err = 1'b1;
                else           result = a_ext % b_ext;
            end
            default: result = '0;
        endcase
    end

endmodule : instr_alu

// File: rtl/instr_register_alu.sv
// instr_register_alu
// DEPTH-entry instruction register with a one-stage compute pipeline on the
// write path and a registered read port.
// A write is captured on one edge and committed on the next edge, together
// with its ALU result. A read on the commit edge of the same entry sees the
// new data, because the read port is write-first.
// Ports:
//   clk, reset                        clock, async active-high reset
//   load_en, write_pointer            write request and entry index
//   opcode, operand_a, operand_b      instruction to store and execute
//   read_en, read_pointer             read request and entry index
//   rd_valid                          read data valid, one cycle after read_en
//   rd_hit                            the entry read was valid
//   rd_opcode, rd_operand_a/b         stored instruction fields
//   rd_result, rd_err                 stored result and divide-by-zero flag
//   entry_count                       number of valid entries
module instr_register_alu
    import instr_register_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [AW-1:0]        write_pointer,
    input  opcode_t              opcode,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    input  logic                 read_en,
    input  logic [AW-1:0]        read_pointer,
    output logic                 rd_valid,
    output logic                 rd_hit,
    output opcode_t              rd_opcode,
    output logic [WIDTH-1:0]     rd_operand_a,
    output logic [WIDTH-1:0]     rd_operand_b,
    output logic [2*WIDTH-1:0]   rd_result,
    output logic                 rd_err,
    output logic [AW:0]          entry_count
);

    // Stage 1 pipeline registers
    logic                 s1_valid;
    logic [AW-1:0]        s1_ptr;
    opcode_t              s1_opcode;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;

    // Entry storage
    logic                 ent_valid  [DEPTH];
    opcode_t              ent_opcode [DEPTH];
    logic [WIDTH-1:0]     ent_a      [DEPTH];
    logic [WIDTH-1:0]     ent_b      [DEPTH];
    logic [2*WIDTH-1:0]   ent_result [DEPTH];
    logic                 ent_err    [DEPTH];

    // Stage 2 ALU output
    logic [2*WIDTH-1:0]   alu_result;
    logic                 alu_err;

    logic                 forward_hit;
    logic                 commit_new;

    instr_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .opcode (s1_opcode),
        .a      (s1_a),
        .b      (s1_b),
        .result (alu_result),
        .err    (alu_err)
    );

    // A commit that lands on the entry being read this edge is returned
    // directly from stage 2.
    assign forward_hit = s1_valid && (s1_ptr == read_pointer);

    // The count grows only when a previously empty entry is filled. It
    // therefore cannot exceed DEPTH and needs no saturation logic.
    assign commit_new  = s1_valid && !ent_valid[s1_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_ptr    <= '0;
            s1_opcode <= ZERO;
            s1_a      <= '0;
            s1_b      <= '0;
        end else begin
            s1_valid <= load_en;
            if (load_en) begin
                s1_ptr    <= write_pointer;
                s1_opcode <= opcode;
                s1_a      <= operand_a;
                s1_b      <= operand_b;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i]  <= 1'b0;
                ent_opcode[i] <= ZERO;
                ent_a[i]      <= '0;
                ent_b[i]      <= '0;
                ent_result[i] <= '0;
                ent_err[i]    <= 1'b0;
            end
        end else if (s1_valid) begin
            ent_valid[s1_ptr]  <= 1'b1;
            ent_opcode[s1_ptr] <= s1_opcode;
            ent_a[s1_ptr]      <= s1_a;
            ent_b[s1_ptr]      <= s1_b;
            ent_result[s1_ptr] <= alu_result;
            ent_err[s1_ptr]    <= alu_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_count <= '0;
        end else if (commit_new) begin
            entry_count <= entry_count + (AW+1)'(1);
        end
    end

    // Registered read port. The rd_* fields hold their last value while
    // read_en is low, and only rd_valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid     <= 1'b0;
            rd_hit       <= 1'b0;
            rd_opcode    <= ZERO;
            rd_operand_a <= '0;
            rd_operand_b <= '0;
            rd_result    <= '0;
            rd_err       <= 1'b0;
        end else begin
            rd_valid <= read_en;
            if (read_en) begin
                if (forward_hit) begin
                    rd_hit       <= 1'b1;
                    rd_opcode    <= s1_opcode;
                    rd_operand_a <= s1_a;
                    rd_operand_b <= s1_b;
                    rd_result    <= alu_result;
                    rd_err       <= alu_err;
                end else begin
                    rd_hit       <= ent_valid[read_pointer];
                    rd_opcode    <= ent_opcode[read_pointer];
                    rd_operand_a <= ent_a[read_pointer];
                    rd_operand_b <= ent_b[read_pointer];
                    rd_result    <= ent_result[read_pointer];
                    rd_err       <= ent_err[read_pointer];
                end
            end
        end
    end

endmodule : instr_register_alu

// File: doc/instr_register_alu.md
Name: instr_register_alu

Overview:
- Parametrised successor to the instruction register stack.
- Stores DEPTH instruction entries, each holding opcode, two signed operands, a computed result and flags.
- Results are computed in a one-stage pipeline on the write path and read through a registered read port.
- Sits between the stimulus driver and the checker/scoreboard. Adds per-entry valid bits, an occupancy count, a divide-by-zero flag and write-to-read forwarding.

Parameters:
- WIDTH, 8: operand width in bits, signed, ≥ 2.
- DEPTH, 32: number of register entries, power of two, ≥ 2.
- AW, $clog2(DEPTH): pointer width, derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load_en  in  1  write request this cycle.
- write_pointer  in  AW  write entry index.
- opcode  in  opcode_t (3)  operation to store and execute.
- operand_a  in  WIDTH  signed operand A.
- operand_b  in  WIDTH  signed operand B.
- read_en  in  1  read request this cycle.
- read_pointer  in  AW  read entry index.
- rd_valid  out  1  read data valid, one cycle after read_en.
- rd_hit  out  1  the read entry held a committed instruction.
- rd_opcode  out  opcode_t  stored opcode.
- rd_operand_a  out  WIDTH  stored operand A.
- rd_operand_b  out  WIDTH  stored operand B.
- rd_result  out  2*WIDTH  stored signed result.
- rd_err  out  1  stored divide-by-zero flag.
- entry_count  out  AW+1  number of valid entries.

Behaviour:
- Reset (asynchronous assert, synchronous release): clears all valid bits and all entry fields to 0. Outputs reset to: rd_valid=0, rd_hit=0, rd_opcode=ZERO, rd_* fields=0, rd_err=0, entry_count=0. Reset mid-pipeline discards any captured write.
- Stage 1 (edge N with load_en=1): capture write_pointer, opcode, operand_a and operand_b into pipeline registers and set s1_valid.
- Stage 2 (edge N+1): compute the result and commit it into entry[ptr] with valid=1. Write-to-storage latency is 2 edges. Back-to-back writes every cycle are supported at full throughput.
- Arithmetic: operands are sign-extended to 2*WIDTH.
  - ZERO: 0.
  - PASSA: a.
  - PASSB: b.
  - ADD: a+b.
  - SUB: a-b.
  - MULT: a*b, full signed product with no truncation.
  - DIV: a/b, truncating toward zero.
  - MOD: a%b, sign follows a.
  - DIV or MOD with b=0: result=0, err=1. All other cases: err=0.
- Read: at edge M with read_en=1, the rd_* outputs take entry[read_pointer] and rd_valid=1 from M until the next edge. With read_en=0 the next edge drives rd_valid=0 and rd_* hold their last value.
- rd_hit: equals the entry's valid bit. An invalid entry returns zeros with rd_hit=0.
- Forwarding: if read_en is asserted on the same edge that stage 2 commits to read_pointer, the read returns the newly committed values with rd_hit=1 (write-first).
- Overwrite: a write to an already-valid entry replaces every field and leaves entry_count unchanged.
- entry_count: increments on a commit to a previously invalid entry. It saturates at DEPTH, which is structural: every entry valid means count=DEPTH. There is no decrement path except reset.
- Same-address writes on consecutive cycles: commits occur in order and the last write wins.
- Pointers are exactly AW bits, so there is no out-of-range index.

Decomposition:
- Shared package instr_register_pkg:
  - opcode_t enum (ZERO=0, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD=7).
  - Opcode width constant.
  - No width-dependent typedefs, because WIDTH is a module parameter.
- One sub-module, instr_alu: purely combinational. Inputs are opcode, a and b (parameter WIDTH); outputs are the 2*WIDTH result and err. Stage 2 instantiates it, and the bench reuses it as the reference model.

Test Plan:
- Reset, then read entry 5 -> rd_valid=1 one cycle later, rd_hit=0, rd_result=0, entry_count=0.
- Write entry 3: ADD, a=-15, b=15; read 3 after 2 edges -> rd_hit=1, rd_result=0, rd_err=0, entry_count=1.
- Write entry 7: MULT, a=-128, b=-128 -> rd_result=16384. Write entry 8: DIV, a=-7, b=2 -> rd_result=-3. Write entry 9: MOD, a=-7, b=2 -> rd_result=-1.
- Write entry 4: DIV, a=10, b=0 -> rd_result=0, rd_err=1. Overwrite entry 4 with SUB, a=10, b=0 -> rd_result=10, rd_err=0, entry_count unchanged.
- Write entry 12: PASSB, b=9, with read_en on entry 12 at the commit edge -> the read returns opcode PASSB, rd_result=9, rd_hit=1 (forwarding).
- Write all 32 entries on back-to-back cycles -> entry_count=32 after the final commit. Assert reset with one write in stage 1 -> entry_count=0, all rd_hit=0, and the captured write is never committed.
